// File: rtl/pc_sequencer_if.sv
// Handshake bundle between decode/branch resolution and the PC sequencer.
// The master side drives redirect requests, and the slave side returns the PC state.
interface pc_sequencer_if;
  logic        advance;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        jump;
  logic [31:0] jump_addr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        in_delay_slot;
  logic        active;
  logic        addr_error;

  modport master (
    output advance, branch_taken, branch_addr, jump, jump_addr,
    input  pc, pc_plus4, in_delay_slot, active, addr_error
  );

  modport slave (
    input  advance, branch_taken, branch_addr, jump, jump_addr,
    output pc, pc_plus4, in_delay_slot, active, addr_error
  );
endinterface

// File: rtl/pc_sequencer.sv
// MIPS program-counter owner. It handles the branch delay slot, stall hold,
// halt on a redirect to HALT_ADDR, and a sticky misaligned-target error.
module pc_sequencer #(
  parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
  parameter logic [31:0] HALT_ADDR    = 32'h00000000
) (
  input logic           clk,
  input logic           reset,
  pc_sequencer_if.slave bus
);

  localparam int unsigned AW = 32;

  localparam logic [1:0] ST_RUN    = 2'd0;
  localparam logic [1:0] ST_DELAY  = 2'd1;
  localparam logic [1:0] ST_HALTED = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] pending_q, pending_d;
  logic          in_ds_q, in_ds_d;
  logic          active_q, active_d;
  logic          addr_err_q, addr_err_d;

  logic [AW-1:0] pc_plus4_c;
  logic [AW-1:0] target_c;

  assign pc_plus4_c = pc_q + AW'(4);
  // Jump wins over a simultaneously resolved branch.
  assign target_c   = bus.jump ? bus.jump_addr : bus.branch_addr;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_VECTOR;
      pending_q  <= '0;
      in_ds_q    <= 1'b0;
      active_q   <= 1'b1;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      pending_q  <= pending_d;
      in_ds_q    <= in_ds_d;
      active_q   <= active_d;
      addr_err_q <= addr_err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    pending_d  = pending_q;
    in_ds_d    = in_ds_q;
    active_d   = active_q;
    addr_err_d = addr_err_q;

    if (bus.advance) begin
      case (state_q)
        ST_RUN: begin
          if (bus.jump || bus.branch_taken) begin
            // A misaligned target aborts before the delay slot executes.
            if (target_c[1:0] != 2'b00) begin
              addr_err_d = 1'b1;
              active_d   = 1'b0;
              state_d    = ST_HALTED;
            end else begin
              pending_d = target_c;
              pc_d      = pc_plus4_c;
              in_ds_d   = 1'b1;
              state_d   = ST_DELAY;
            end
          end else begin
            pc_d = pc_plus4_c;
          end
        end
        ST_DELAY: begin
          // Redirect requests from the delay-slot instruction are ignored.
          pc_d    = pending_q;
          in_ds_d = 1'b0;
          if (pending_q == HALT_ADDR) begin
            active_d = 1'b0;
            state_d  = ST_HALTED;
          end else begin
            state_d = ST_RUN;
          end
        end
        default: begin
          state_d = ST_HALTED;
        end
      endcase
    end
  end

  assign bus.pc            = pc_q;
  assign bus.pc_plus4      = pc_plus4_c;
  assign bus.in_delay_slot = in_ds_q;
  assign bus.active        = active_q;
  assign bus.addr_error    = addr_err_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: sequential flow, delay slot, stalls, halt,
// misaligned target, reset in DELAY, and 32-bit wrap.
module tb_pc_sequencer;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_VECTOR(32'hBFC00000),
    .HALT_ADDR   (32'h00000000)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the rising edge.
  task automatic step(input logic rst, input logic adv,
                      input logic br, input logic [31:0] ba,
                      input logic j,  input logic [31:0] ja);
    reset            = rst;
    bus.advance      = adv;
    bus.branch_taken = br;
    bus.branch_addr  = ba;
    bus.jump         = j;
    bus.jump_addr    = ja;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_state(input string tag, input logic [31:0] pc,
                              input logic ds, input logic act, input logic aerr);
    check_eq({tag, ".pc"},  bus.pc, pc);
    check_eq({tag, ".ds"},  32'(bus.in_delay_slot), 32'(ds));
    check_eq({tag, ".act"}, 32'(bus.active), 32'(act));
    check_eq({tag, ".err"}, 32'(bus.addr_error), 32'(aerr));
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    bus.advance = 1'b0;
    bus.branch_taken = 1'b0;
    bus.branch_addr = '0;
    bus.jump = 1'b0;
    bus.jump_addr = '0;

    // Reset and plain sequential flow
    step(1, 0, 0, 0, 0, 0);
    expect_state("rst", 32'hBFC00000, 0, 1, 0);
    check_eq("rst.pc4", bus.pc_plus4, 32'hBFC00004);
    step(0, 1, 0, 0, 0, 0); expect_state("seq1", 32'hBFC00004, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0); expect_state("seq2", 32'hBFC00008, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0); expect_state("seq3", 32'hBFC0000C, 0, 1, 0);

    // Get to pc = 16 with a jump
    step(0, 1, 0, 0, 1, 32'd16); expect_state("j16.ds", 32'hBFC00010, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0);      expect_state("j16.tg", 32'd16, 0, 1, 0);

    // Taken branch to 48
    step(0, 1, 1, 32'd48, 0, 0); expect_state("br.ds", 32'd20, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0);      expect_state("br.tg", 32'd48, 0, 1, 0);

    // Back to 16, then branch with stalls and a branch in the delay slot
    step(0, 1, 0, 0, 1, 32'd16); expect_state("j16b.ds", 32'd52, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0);      expect_state("j16b.tg", 32'd16, 0, 1, 0);
    step(0, 1, 1, 32'd48, 0, 0); expect_state("st.ds", 32'd20, 1, 1, 0);
    step(0, 0, 1, 32'd200, 0, 0); expect_state("st.hold1", 32'd20, 1, 1, 0);
    step(0, 0, 1, 32'd200, 0, 0); expect_state("st.hold2", 32'd20, 1, 1, 0);
    step(0, 1, 1, 32'd200, 0, 0); expect_state("st.tg", 32'd48, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0);      expect_state("st.run", 32'd52, 0, 1, 0);

    // Reset while in DELAY with 48 pending
    step(0, 1, 1, 32'd48, 0, 0); expect_state("rd.ds", 32'd56, 1, 1, 0);
    step(1, 1, 0, 0, 0, 0);      expect_state("rd.rst", 32'hBFC00000, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0);      expect_state("rd.seq", 32'hBFC00004, 0, 1, 0);

    // Wrap-around from FFFFFFFC does not halt
    step(0, 1, 0, 0, 1, 32'hFFFFFFFC); expect_state("wr.ds", 32'hBFC00008, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0);      expect_state("wr.top", 32'hFFFFFFFC, 0, 1, 0);
    check_eq("wr.pc4", bus.pc_plus4, 32'h00000000);
    step(0, 1, 0, 0, 0, 0);      expect_state("wr.zero", 32'h00000000, 0, 1, 0);
    step(0, 1, 0, 0, 0, 0);      expect_state("wr.four", 32'h00000004, 0, 1, 0);

    // Jump beats branch; jump to 0 halts after the delay slot
    step(0, 1, 0, 0, 1, 32'd40); expect_state("j40.ds", 32'd8, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0);      expect_state("j40.tg", 32'd40, 0, 1, 0);
    step(0, 1, 1, 32'd8, 1, 32'd0); expect_state("h.ds", 32'd44, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0);      expect_state("h.halt", 32'd0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 32'd16); expect_state("h.frz1", 32'd0, 0, 0, 0);
    step(0, 1, 1, 32'd64, 0, 0); expect_state("h.frz2", 32'd0, 0, 0, 0);

    // Misaligned branch target from pc = 8
    step(1, 0, 0, 0, 0, 0);      expect_state("m.rst", 32'hBFC00000, 0, 1, 0);
    step(0, 1, 0, 0, 1, 32'd8);  expect_state("m.ds", 32'hBFC00004, 1, 1, 0);
    step(0, 1, 0, 0, 0, 0);      expect_state("m.at8", 32'd8, 0, 1, 0);
    step(0, 1, 1, 32'd131078, 0, 0); expect_state("m.err", 32'd8, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0);      expect_state("m.hold", 32'd8, 0, 0, 1);
    step(1, 0, 0, 0, 0, 0);      expect_state("m.clr", 32'hBFC00000, 0, 1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
